// File: rtl/recv_addr_presenter.sv
// ---------------------------------------------------------------------------
// recv_addr_presenter
//
// Feeds the 8-bit receive-address PIO input port read by the Nios. Header
// words from the network receive interface are accepted with a valid/ready
// handshake. The 7-bit source-address field of each word is buffered in a
// small circular FIFO. Addresses are then presented one at a time on
// addr_port. Bit 7 is a "new" level whose rising edge is captured by the PIO.
// The Nios acknowledges each address with a 4-phase handshake on nios_ack.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   hdr_data    header word; address is hdr_data[ADDR_LSB+6:ADDR_LSB]
//   hdr_valid   hdr_data valid
//   hdr_ready   block can accept hdr_data this cycle (!full)
//   nios_ack    acknowledge level from the Nios output PIO (asynchronous)
//   addr_port   to PIO in_port: [7] new-strobe, [6:0] address
//   fifo_level  current FIFO occupancy (status only)
//
// Parameters:
//   DEPTH       FIFO entries; power of two, 2..16
//   ADDR_LSB    bit position of the 7-bit address field inside hdr_data
// ---------------------------------------------------------------------------
module recv_addr_presenter #(
  parameter int DEPTH    = 4,
  parameter int ADDR_LSB = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              hdr_data,
  input  logic                     hdr_valid,
  output logic                     hdr_ready,
  input  logic                     nios_ack,
  output logic [7:0]               addr_port,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_RELEASE
  } state_t;

  // FIFO storage and bookkeeping
  logic [6:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;

  // Holds hdr_ready low until the first clock after reset release
  logic          r_rdy_en;

  // nios_ack synchroniser
  logic          r_ack_meta;
  logic          r_ack_s;

  // Presentation FSM and its registered output
  state_t        r_state;
  logic [7:0]    r_addr_port;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [6:0]    w_addr;
  logic          w_unused_hdr;

  assign w_addr  = hdr_data[ADDR_LSB +: 7];
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  assign hdr_ready = r_rdy_en & ~w_full;
  assign w_push    = hdr_valid & hdr_ready;

  // Pop is only requested from IDLE, with data present and the Nios idle.
  // A Nios that still holds ack high stalls the FSM here without popping.
  assign w_pop = (r_state == S_IDLE) & ~w_empty & ~r_ack_s;

  // Only the address field is consumed; the rest of the header is ignored.
  assign w_unused_hdr = ^hdr_data;

  assign addr_port  = r_addr_port;
  assign fifo_level = r_count;

  // NOTE: storage is not reset -- entries are only ever read after being
  // written, and the pointers/occupancy (which are reset) define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_addr;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Two-flop synchroniser; r_ack_s is the only version the FSM looks at.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= nios_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Presentation FSM. Bit 7 is low in IDLE and RELEASE, so there is always
  // at least one low cycle between two presentations. Each address therefore
  // produces exactly one rising edge at the PIO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr_port <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_addr_port <= {1'b1, r_mem[r_rd_ptr]};
            r_state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (r_ack_s) begin
            // The address bits are kept; only the strobe drops
            r_addr_port[7] <= 1'b0;
            r_state        <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!r_ack_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_addr_port[7] <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recv_addr_presenter.sv
// ---------------------------------------------------------------------------
// tb_recv_addr_presenter
//
// Bench for recv_addr_presenter (DEPTH=4, ADDR_LSB=24). Every accepted
// header pushes its expected port value into exp_q. A monitor pops exp_q on
// each 0->1 transition of addr_port[7] and compares the values. Directed
// checks cover reset, latency, back-pressure, the protocol-error stall and
// reset during a presentation.
// ---------------------------------------------------------------------------
module tb_recv_addr_presenter;

  localparam int DEPTH    = 4;
  localparam int ADDR_LSB = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] hdr_data;
  logic        hdr_valid;
  logic        hdr_ready;
  logic        nios_ack;
  logic [7:0]  addr_port;
  logic [2:0]  fifo_level;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rise_cnt = 0;
  logic [7:0]  exp_q [$];
  logic        auto_ack = 1'b0;
  logic        man_ack  = 1'b0;
  logic        prev7    = 1'b0;

  always #5 clk = ~clk;

  recv_addr_presenter #(
    .DEPTH    (DEPTH),
    .ADDR_LSB (ADDR_LSB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hdr_data   (hdr_data),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .nios_ack   (nios_ack),
    .addr_port  (addr_port),
    .fifo_level (fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one header word until accepted, then records the expected value.
  task automatic push(input logic [6:0] a);
    int n = 0;
    @(negedge clk);
    hdr_data  = 32'(a) << ADDR_LSB;
    hdr_valid = 1'b1;
    while (!hdr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept_timeout", 32'(n >= 200), 32'd0);
    exp_q.push_back({1'b1, a});
    @(posedge clk);
    #1 hdr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
  endtask

  // Nios model: in auto mode it follows the strobe (fast 4-phase ack),
  // otherwise it replays the level chosen by the directed sequence.
  initial begin
    nios_ack = 1'b0;
    forever begin
      @(negedge clk);
      nios_ack = auto_ack ? addr_port[7] : man_ack;
    end
  end

  // Scoreboard monitor: one expected entry per rising strobe.
  always @(negedge clk) begin
    if (reset_n && !prev7 && addr_port[7]) begin
      rise_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_present: got 0x%0h, expected no presentation at %0t",
                 addr_port, $time);
      end else begin
        check("present", 32'(addr_port), 32'(exp_q.pop_front()));
      end
    end
    prev7 = addr_port[7];
  end

  initial begin
    int base;
    reset_n   = 1'b0;
    hdr_valid = 1'b0;
    hdr_data  = '0;

    // ---------------- Reset then idle ----------------
    repeat (3) @(posedge clk);
    #2;
    check("reset_port",  32'(addr_port),  32'h00);
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_ready", 32'(hdr_ready),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_before_edge", 32'(hdr_ready), 32'd0);
    @(posedge clk);
    #1 check("ready_after_release", 32'(hdr_ready), 32'd1);

    // ---------------- Single address ----------------
    push(7'h2A);
    check("single_level_push", 32'(fifo_level), 32'd1);
    check("single_port_push",  32'(addr_port),  32'h00);
    @(posedge clk);
    #1 check("single_present",    32'(addr_port),  32'hAA);
    check("single_level_pop",     32'(fifo_level), 32'd0);
    repeat (4) @(posedge clk);
    #1 man_ack = 1'b1;
    @(posedge clk);
    #1 check("ack_edge1", 32'(addr_port), 32'hAA);
    @(posedge clk);
    #1 check("ack_edge2", 32'(addr_port), 32'hAA);
    @(posedge clk);
    #1 check("ack_edge3", 32'(addr_port), 32'h2A);
    @(posedge clk);
    #1 man_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("single_after_fall", 32'(addr_port), 32'h2A);
    repeat (3) @(posedge clk);

    // ---------------- Fill and back-pressure ----------------
    for (int i = 1; i <= 5; i++) push(7'(i));
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_ready", 32'(hdr_ready),  32'd0);
    check("fill_port",  32'(addr_port),  32'h81);
    fork
      push(7'h06);
    join_none
    repeat (3) @(posedge clk);
    #1 check("stall_level", 32'(fifo_level), 32'd4);
    check("stall_ready", 32'(hdr_ready),  32'd0);
    check("stall_port",  32'(addr_port),  32'h81);
    auto_ack = 1'b1;
    wait_drain("fill", 300);
    wait fork;
    repeat (12) @(posedge clk);
    auto_ack = 1'b0;
    #1 check("fill_end_level", 32'(fifo_level), 32'd0);
    check("fill_end_port", 32'(addr_port), 32'h06);
    repeat (3) @(posedge clk);

    // ---------------- Protocol error, then simultaneous push/pop ----------------
    #1 man_ack = 1'b1;
    repeat (3) @(posedge clk);
    push(7'h10);
    push(7'h11);
    repeat (4) @(posedge clk);
    #1 check("perr_level", 32'(fifo_level), 32'd2);
    check("perr_port", 32'(addr_port), 32'h06);
    man_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("simul_level_before", 32'(fifo_level), 32'd2);
    push(7'h12);
    check("simul_level", 32'(fifo_level), 32'd2);
    check("simul_port",  32'(addr_port),  32'h90);
    auto_ack = 1'b1;
    wait_drain("simul", 300);
    repeat (12) @(posedge clk);
    auto_ack = 1'b0;
    #1 check("simul_end_level", 32'(fifo_level), 32'd0);
    check("simul_end_port", 32'(addr_port), 32'h12);

    // ---------------- Pointer wrap ----------------
    auto_ack = 1'b1;
    base = rise_cnt;
    for (int i = 0; i < 20; i++) push(7'(i));
    wait_drain("wrap", 600);
    repeat (12) @(posedge clk);
    auto_ack = 1'b0;
    #1 check("wrap_rises", 32'(rise_cnt - base), 32'd20);
    check("wrap_level", 32'(fifo_level), 32'd0);
    check("wrap_port",  32'(addr_port),  32'h13);
    repeat (3) @(posedge clk);

    // ---------------- Reset mid-presentation ----------------
    push(7'h33);
    push(7'h34);
    push(7'h35);
    @(posedge clk);
    #3 check("pre_reset_port", 32'(addr_port),  32'hB3);
    check("pre_reset_level", 32'(fifo_level), 32'd2);
    reset_n = 1'b0;
    #1 check("mid_reset_port", 32'(addr_port),  32'h00);
    check("mid_reset_level", 32'(fifo_level), 32'd0);
    check("mid_reset_ready", 32'(hdr_ready),  32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("post_reset_port", 32'(addr_port),  32'h00);
    check("post_reset_level", 32'(fifo_level), 32'd0);
    check("post_reset_ready", 32'(hdr_ready),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
